// File: rtl/uart_pkg.sv
// Shared UART constants and frame-state encoding, used by the transmitter and receiver.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Counts tx_clk_en ticks within one bit period and flags the period's final tick.
module uart_tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  assign terminal = tick & ~clear & (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with one-byte holding register; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_clk_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
  localparam int CNT_W      = $clog2(STOP_TICKS);

  uart_state_e          state;
  logic [DATA_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 accept;
  logic                 bit_end;
  logic [CNT_W-1:0]     tick_limit;

  // The holding register is full exactly when tx_ready is low.
  assign accept     = tx_start & tx_ready;
  assign tick_limit = (state == STOP) ? CNT_W'(STOP_TICKS - 1) : CNT_W'(OVERSAMPLE - 1);

  uart_tick_counter #(
    .WIDTH (CNT_W)
  ) u_tick_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .tick     (tx_clk_en),
    .limit    (tick_limit),
    .terminal (bit_end)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of state, tx_ready and bit_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_line   <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      bit_idx   <= '0;
      hold_reg  <= '0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_busy <= (state != IDLE) || !tx_ready || accept;

      if (accept) begin
        hold_reg <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tx_clk_en && !tx_ready) begin
            shift_reg <= hold_reg;
            tx_ready  <= 1'b1;
            tx_line   <= ~IDLE_LEVEL;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx_line <= shift_reg[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_line <= even_parity(shift_reg);
              state   <= PARITY;
`else
              tx_line <= IDLE_LEVEL;
              state   <= STOP;
`endif
            end else begin
              tx_line <= shift_reg[bit_idx + 3'd1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_line <= IDLE_LEVEL;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            if (!tx_ready) begin
              // Queued byte starts immediately: no idle-high gap between frames.
              shift_reg <= hold_reg;
              tx_ready  <= 1'b1;
              tx_line   <= ~IDLE_LEVEL;
              state     <= START;
            end else begin
              tx_busy <= accept;
              state   <= IDLE;
            end
          end
        end

        default: begin
          tx_line <= IDLE_LEVEL;
          tx_busy <= !tx_ready || accept;
          bit_idx <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: tick-level frame model compared every cycle, plus literal frame checks.
module tb_uart_transmitter;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en;
  logic [1:0] start = 2'b00;
  logic [7:0] data [2];
  logic [1:0] line, ready, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_prt  = 0;
  int cyc    = 0;
  int done_cnt [2];

  always #5 clk = ~clk;

  // Instance 0: baud tick every clk, one stop bit. Instance 1: tick every 4th clk, two stop bits.
  uart_transmitter #(.OVERSAMPLE(OS), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_clk_en(en[0]), .tx_start(start[0]), .tx_data(data[0]),
    .tx_line(line[0]), .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_transmitter #(.OVERSAMPLE(OS), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_clk_en(en[1]), .tx_start(start[1]), .tx_data(data[1]),
    .tx_line(line[1]), .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  initial begin
    int div = 0;
    en = 2'b01;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      en  = {div == 0, 1'b1};
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_active [2];
  bit          m_full   [2];
  logic [7:0]  m_hold   [2];
  logic [11:0] m_bits   [2];
  int          m_pos    [2];
  int          m_len    [2];
  logic        m_line   [2];
  logic        m_ready  [2];
  logic        m_busy   [2];
  logic        m_done   [2];

  function automatic logic [11:0] frame_of(input logic [7:0] d);
    logic [11:0] b = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (PAR == 1) b[9] = ^d;
    return b;
  endfunction

  task automatic model_begin_frame(input int i);
    m_bits[i]   = frame_of(m_hold[i]);
    m_len[i]    = (1 + 8 + PAR + (i == 0 ? 1 : 2)) * OS;
    m_pos[i]    = 0;
    m_active[i] = 1'b1;
    m_full[i]   = 1'b0;
    m_ready[i]  = 1'b1;
    m_line[i]   = 1'b0;
  endtask

  task automatic model_step(input int i);
    bit acc;
    if (rst) begin
      m_active[i] = 1'b0;
      m_full[i]   = 1'b0;
      m_pos[i]    = 0;
      m_line[i]   = 1'b1;
      m_ready[i]  = 1'b1;
      m_busy[i]   = 1'b0;
      m_done[i]   = 1'b0;
    end else begin
      acc       = start[i] && m_ready[i];
      m_done[i] = 1'b0;
      if (en[i]) begin
        if (m_active[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) begin
            m_done[i]   = 1'b1;
            m_active[i] = 1'b0;
            m_line[i]   = 1'b1;
          end else begin
            m_line[i] = m_bits[i][m_pos[i] / OS];
          end
        end
        if (!m_active[i] && m_full[i]) model_begin_frame(i);
      end
      if (acc) begin
        m_hold[i]  = data[i];
        m_full[i]  = 1'b1;
        m_ready[i] = 1'b0;
      end
      m_busy[i] = m_active[i] || m_full[i];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({line[i], ready[i], busy[i], done[i]} !==
          {m_line[i], m_ready[i], m_busy[i], m_done[i]}) begin
        n_fail++;
        if (n_prt < 20) begin
          n_prt++;
          $display("FAIL cycle_cmp[%0d] cyc=%0d line/ready/busy/done got %b%b%b%b want %b%b%b%b",
                   i, cyc, line[i], ready[i], busy[i], done[i],
                   m_line[i], m_ready[i], m_busy[i], m_done[i]);
        end
      end
      if (done[i] === 1'b1) done_cnt[i]++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_start(input int i, input logic [7:0] d);
    start[i] = 1'b1;
    data[i]  = d;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    @(negedge clk);
    pulse_start(i, d);
  endtask

  task automatic wait_line_low(input int i, input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (line[i] === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
    check({tag, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int i, input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_ready(input int i, input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (ready[i] === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Called at the negedge where the start bit has just begun.
  task automatic sample_byte(input int i, input int bitlen, output logic [7:0] b);
    repeat (bitlen + bitlen / 2) @(negedge clk);
    b[0] = line[i];
    for (int k = 1; k < 8; k++) begin
      repeat (bitlen) @(negedge clk);
      b[k] = line[i];
    end
  endtask

  task automatic frame_check(input int i, input logic [7:0] d, input logic [11:0] exp_bits,
                             input int nbits, input int bitlen, input int exp_len,
                             input string tag);
    int c0;
    bit ok;
    send(i, d);
    wait_line_low(i, tag, ok);
    if (!ok) return;
    c0 = cyc;
    for (int k = 0; k < nbits; k++) begin
      repeat (k == 0 ? bitlen / 2 : bitlen) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, k), line[i], exp_bits[k]);
    end
    wait_done(i, tag, ok);
    if (ok) check({tag, "_len"}, cyc - c0, exp_len);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit          ok;
    int          c1, d0;
    logic [7:0]  rx;

    data[0] = '0;
    data[1] = '0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_line%0d",  i), line[i],  1);
      check($sformatf("reset_ready%0d", i), ready[i], 1);
      check($sformatf("reset_busy%0d",  i), busy[i],  0);
      check($sformatf("reset_done%0d",  i), done[i],  0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, then 0x07: LSB-first frames with optional parity.
`ifdef UART_TX_PARITY_EN
    frame_check(0, 8'hA5, 12'b1101_0100_1010, 11, OS, 176, "a5");
    frame_check(0, 8'h07, 12'b1110_0000_1110, 11, OS, 176, "07");
`else
    frame_check(0, 8'hA5, 12'b1111_0100_1010, 10, OS, 160, "a5");
    frame_check(0, 8'h07, 12'b1110_0000_1110, 10, OS, 160, "07");
`endif
    repeat (10) @(negedge clk);

    // 0x55 then 0x0F written as soon as tx_ready rises: frames abut.
    d0 = done_cnt[0];
    send(0, 8'h55);
    wait_ready(0, "b2b", ok);
    pulse_start(0, 8'h0F);
    wait_done(0, "b2b_first", ok);
    c1 = cyc;
    check("b2b_no_gap_line", line[0], 0);
    wait_done(0, "b2b_second", ok);
    check("b2b_second_len", cyc - c1, (PAR == 1) ? 176 : 160);
    @(negedge clk);
    check("b2b_done_pulses", done_cnt[0] - d0, 2);
    repeat (10) @(negedge clk);

    // 0x3C in flight, 0x81 queued, 0x12 offered while tx_ready=0 is dropped.
    send(0, 8'h3C);
    wait_ready(0, "ign", ok);
    pulse_start(0, 8'h81);
    repeat (3) @(negedge clk);
    check("ign_ready_low", ready[0], 0);
    pulse_start(0, 8'h12);
    wait_done(0, "ign_first", ok);
    sample_byte(0, OS, rx);
    check("ign_second_byte", rx, 8'h81);
    wait_done(0, "ign_second", ok);
    repeat (50) @(negedge clk);
    check("ign_idle_busy", busy[0], 0);
    check("ign_idle_line", line[0], 1);

    // Reset in the middle of data bit 3 with a byte queued.
    send(0, 8'hC3);
    wait_ready(0, "rst", ok);
    pulse_start(0, 8'h99);
    repeat (69) @(negedge clk);
    d0 = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_line",  line[0],  1);
    check("rst_ready", ready[0], 1);
    check("rst_busy",  busy[0],  0);
    check("rst_done",  done[0],  0);
    repeat (300) @(negedge clk);
    check("rst_no_done", done_cnt[0] - d0, 0);
    check("rst_still_idle", line[0], 1);

    // Slow baud tick (every 4th clk), two stop bits, 0xFF.
`ifdef UART_TX_PARITY_EN
    frame_check(1, 8'hFF, 12'b1101_1111_1110, 11, 4 * OS, 768, "ff_slow");
`else
    frame_check(1, 8'hFF, 12'b1111_1111_1110, 10, 4 * OS, 704, "ff_slow");
`endif
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, 16, tx_clk_en ticks per bit period (power of two, 8..32).
REQ-002 SHALL have parameter: STOP_BITS, 1, number of stop bit periods (1 or 2).
REQ-003 SHALL have one clock and a reset that is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: tx_clk_en  input  1  oversampled baud enable; one-clk pulse, OVERSAMPLE per bit.
REQ-007 SHALL have port: tx_start  input  1  request to load tx_data into the holding register.
REQ-008 SHALL have port: tx_data  input  8  byte to send, sampled when tx_start is accepted.
REQ-009 SHALL have port: tx_line  output  1  serial output, registered, idle high.
REQ-010 SHALL have port: tx_ready  output  1  holding register empty; tx_start is accepted only while it is high.
REQ-011 SHALL have port: tx_busy  output  1  high while a frame is in flight or the holding register is full.
REQ-012 SHALL have port: tx_done  output  1  one-clk pulse when the final stop period ends.

Function
REQ-013 SHALL transmit frame START(0), 8 data bits LSB first, [PARITY], STOP(1) x STOP_BITS.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only with the macro defined.
REQ-015 SHALL hold each state for exactly OVERSAMPLE tx_clk_en ticks, using a sample counter of 0..OVERSAMPLE-1 that advances only on tx_clk_en.
REQ-016 SHALL accept tx_start when tx_ready=1: capture tx_data in the holding register, with tx_ready=0 from the next clk; tx_start while tx_ready=0 SHALL be ignored, with no state change.
REQ-017 SHALL, in IDLE with the holding register full, on the next tx_clk_en move the byte to the shift register, free the holding register, drive tx_line=0 and enter START.
REQ-018 SHALL update tx_line only on the tx_clk_en tick that begins a new bit period.
REQ-019 SHALL index DATA bits with a 3-bit index and leave DATA after bit 7's last tick.
REQ-020 SHALL count STOP across STOP_BITS*OVERSAMPLE ticks.
REQ-021 SHALL, on the final STOP tick, pulse tx_done for one clk, then go to START directly if the holding register is full (no idle gap), else to IDLE.
REQ-022 SHALL drive tx_busy = (state != IDLE) | holding register full, registered.
REQ-023 SHALL allow tx_start to be accepted in the same clk that the holding register drains; the new byte then forms the next frame.
REQ-024 SHALL hold all state while tx_clk_en=0; tx_start acceptance SHALL NOT depend on tx_clk_en.
REQ-025 SHALL return any illegal state to IDLE with tx_line=1.

Reset
REQ-026 SHALL set, on rst=1 at a clk edge: state=IDLE, tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0, holding register empty.
REQ-027 SHALL have rst take priority over tx_start and tx_clk_en.
REQ-028 SHALL abort a mid-frame frame on rst: tx_line=1 next clk, no tx_done, queued byte discarded.

Configuration
REQ-029 SHALL use macro UART_TX_PARITY_EN: when defined, insert one PARITY period after DATA carrying even parity (XOR of the 8 data bits); when undefined, go DATA->STOP directly and omit parity logic.

Structure
REQ-030 SHALL place the state encoding localparams, DATA_BITS=8 and the IDLE_LEVEL=1 constant in shared package uart_pkg, also used by the receiver.
REQ-031 SHALL use one sub-module, uart_tick_counter (per-bit-period tick counting, terminal-count flag); all other logic SHALL be inline.

Verification
REQ-032 SHALL verify: tx_clk_en=1 every clk, tx_start with 0xA5, macro off -> tx_line 0,1,0,1,0,0,1,0,1,1, each held 16 clks; tx_done pulses at clk 160 after the first START tick.
REQ-033 SHALL verify: macro on, send 0xA5 then 0x07 -> parity bits 0 and 1 respectively; frame length 176 ticks each.
REQ-034 SHALL verify: 0x55, then 0x0F written once tx_ready rises -> second START immediately follows the first STOP, no idle-high gap; two tx_done pulses.
REQ-035 SHALL verify: tx_start 0x12 while tx_ready=0 -> ignored; only the previously queued byte is transmitted.
REQ-036 SHALL verify: rst asserted during DATA bit 3 -> tx_line=1, tx_ready=1, tx_busy=0 next clk; no tx_done.
REQ-037 SHALL verify: tx_clk_en every 4th clk, STOP_BITS=2, send 0xFF -> each bit 64 clks, stop high for 128 clks before tx_done.
